// File: rtl/encrypter_pipe.sv
// encrypter_pipe: two-stage pipelined word encrypter with an internal seedable
// 16-bit Galois LFSR that supplies the per-word mode, key and rotate amount.
//
// Optional feature macro: ENCRYPTER_MODE_CNT_EN adds the mode_cnt port and
// four 16-bit saturating per-mode output counters.
//
// Ports:
//   Clk        clock, all state on rising edge
//   Rst        asynchronous active-high reset
//   in_valid   plaintext word offered
//   in_ready   engine can accept this cycle (combinational from out_ready)
//   in_data    plaintext [DATA_W-1:0]
//   seed_load  load seed into the LFSR this cycle (wins over the advance)
//   seed       new LFSR value, 0 maps to 16'hACE1
//   out_valid  encrypted word available
//   out_ready  consumer takes the word
//   out_data   {mode[1:0], lfsr[15:0], cipher[DATA_W-1:0]}
//   mode_cnt   {cnt3, cnt2, cnt1, cnt0}, only with ENCRYPTER_MODE_CNT_EN
module encrypter_pipe #(
  parameter int unsigned DATA_W = 60,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                seed_load,
  input  logic [15:0]         seed,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W+17:0]  out_data
`ifdef ENCRYPTER_MODE_CNT_EN
  ,
  output logic [63:0]         mode_cnt
`endif
);

  localparam int unsigned OUT_W    = DATA_W + 18;
  localparam int unsigned KEY_REP  = (DATA_W + 15) / 16;
  localparam logic [15:0] SEED_ALT = 16'hACE1;
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? SEED_ALT : SEED;
  localparam logic [15:0] TAPS     = 16'hB400;

  logic [15:0]       lfsr;
  logic [15:0]       lfsr_nxt;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [15:0]       s1_lfsr;
  logic              s1_load;
  logic              s2_load;
  logic              accept;

  logic [KEY_REP*16-1:0] key_rep;
  logic [DATA_W-1:0]     key;
  logic [7:0]            rot_amt;
  logic [2*DATA_W-1:0]   rot_dbl;
  logic [DATA_W-1:0]     rot_data;
  logic [DATA_W-1:0]     cipher;

  // Handshake: each stage is 1-deep, S1 can refill when S2 drains it.
  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;
  assign accept   = in_valid && in_ready;

  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);

  // LFSR: a seed load wins over the per-accept advance.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      lfsr <= SEED_EFF;
    end else if (seed_load) begin
      lfsr <= (seed == 16'h0000) ? SEED_ALT : seed;
    end else if (accept) begin
      lfsr <= lfsr_nxt;
    end
  end

  // S1: captures plaintext together with the LFSR value it will be keyed by.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_lfsr  <= '0;
    end else if (s1_load) begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= in_data;
        s1_lfsr <= lfsr;
      end
    end
  end

  // Key is the snapshot replicated and truncated; rotation via a doubled word.
  assign key_rep  = {KEY_REP{s1_lfsr}};
  assign key      = key_rep[DATA_W-1:0];
  assign rot_amt  = 8'(32'(s1_lfsr[15:8]) % DATA_W);
  assign rot_dbl  = {s1_data, s1_data} << rot_amt;
  assign rot_data = rot_dbl[2*DATA_W-1:DATA_W];

  // Cipher select on the snapshot's low two bits.
  always_comb begin
    cipher = s1_data ^ key;
    case (s1_lfsr[1:0])
      2'd1:    cipher = rot_data ^ key;
      2'd2:    cipher = ~s1_data ^ key;
      2'd3:    cipher = s1_data + key;
      default: cipher = s1_data ^ key;
    endcase
  end

  // S2: output register, held while the consumer stalls.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= {s1_lfsr[1:0], s1_lfsr, cipher};
      end
    end
  end

`ifdef ENCRYPTER_MODE_CNT_EN
  logic [3:0][15:0] cnt_q;
  logic [1:0]       out_mode;

  assign out_mode = out_data[OUT_W-1 -: 2];

  // Per-mode saturating counters of output handshakes.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready && (cnt_q[out_mode] != 16'hFFFF)) begin
      cnt_q[out_mode] <= cnt_q[out_mode] + 16'd1;
    end
  end

  assign mode_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_encrypter_pipe.sv
// Self-checking bench for encrypter_pipe: directed vector table plus
// hand-written stall, seed and reset sequences.
module tb_encrypter_pipe;

  localparam int DW = 60;
  localparam int OW = DW + 18;

  logic          Clk;
  logic          Rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          seed_load;
  logic [15:0]   seed;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
`ifdef ENCRYPTER_MODE_CNT_EN
  logic [63:0]   mode_cnt;
`endif

  int checks = 0;
  int errors = 0;

  encrypter_pipe #(.DATA_W(DW), .SEED(16'hACE1)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .seed_load (seed_load),
    .seed      (seed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef ENCRYPTER_MODE_CNT_EN
    ,
    .mode_cnt  (mode_cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic          ld;
    logic [15:0]   sd;
    logic [DW-1:0] d;
    logic [1:0]    m;
    logic [15:0]   l;
    logic [DW-1:0] c;
  } vec_t;

  vec_t vecs [8];

  function automatic void chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference cipher, built bit by bit.
  function automatic logic [OW-1:0] enc(input logic [DW-1:0] d, input logic [15:0] l);
    logic [DW-1:0] k;
    logic [DW-1:0] rot;
    logic [DW-1:0] c;
    int r;
    r = int'(l[15:8]) % DW;
    for (int i = 0; i < DW; i++) begin
      k[i] = l[i % 16];
      rot[(i + r) % DW] = d[i];
    end
    case (l[1:0])
      2'd0:    c = d ^ k;
      2'd1:    c = rot ^ k;
      2'd2:    c = ~d ^ k;
      default: c = d + k;
    endcase
    return {l[1:0], l, c};
  endfunction

  function automatic logic [DW-1:0] stream_word(input int i);
    return DW'(64'h0FED_CBA9_8765_4321 ^ (64'(i) * 64'h1111_1111_1111_1111));
  endfunction

  // Present one word with no backpressure and check the 2-cycle latency.
  task automatic send_check(input string nm, input logic ld, input logic [15:0] sd,
                            input logic [DW-1:0] d, input logic [OW-1:0] exp);
    @(negedge Clk);
    seed_load = ld;
    seed      = sd;
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b1;
    #1 chk({nm, "_in_ready"}, OW'(in_ready), OW'(1));
    @(negedge Clk);
    seed_load = 1'b0;
    in_valid  = 1'b0;
    #1 chk({nm, "_early_valid"}, OW'(out_valid), OW'(0));
    @(negedge Clk);
    #1;
    chk({nm, "_valid"}, OW'(out_valid), OW'(1));
    chk({nm, "_data"}, out_data, exp);
  endtask

  task automatic load_seed(input logic [15:0] sd);
    @(negedge Clk);
    seed_load = 1'b1;
    seed      = sd;
    in_valid  = 1'b0;
    @(negedge Clk);
    seed_load = 1'b0;
  endtask

  logic [OW-1:0] exp_q [$];
  logic [OW-1:0] held;
  logic [OW-1:0] exp_w;
  logic          stalled_prev;
  logic [15:0]   ml;
  int            sent;
  int            got;
  int            tally [4];

  initial begin
    vecs[0] = '{1'b0, 16'h0000, 60'h000000000000000, 2'd1, 16'hACE1, 60'hCE1ACE1ACE1ACE1};
    vecs[1] = '{1'b0, 16'h0000, 60'h000000000000000, 2'd0, 16'hE270, 60'h270E270E270E270};
    vecs[2] = '{1'b1, 16'h0003, 60'hFFFFFFFFFFFFFFF, 2'd3, 16'h0003, 60'h003000300030002};
    vecs[3] = '{1'b1, 16'h0004, 60'h123456789ABCDEF, 2'd0, 16'h0004, 60'h127456389AFCDEB};
    vecs[4] = '{1'b1, 16'h0006, 60'h0F0F0F0F0F0F0F0, 2'd2, 16'h0006, 60'hF090F090F090F09};
    vecs[5] = '{1'b1, 16'h0501, 60'h000000000000001, 2'd1, 16'h0501, 60'h501050105010521};
    vecs[6] = '{1'b1, 16'h4101, 60'h800000000000000, 2'd1, 16'h4101, 60'h101410141014111};
    vecs[7] = '{1'b1, 16'h8003, 60'h00000000000FFFD, 2'd3, 16'h8003, 60'h003800380048000};

    Rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    seed_load = 1'b0;
    seed = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_out_valid", OW'(out_valid), OW'(0));
    chk("rst_in_ready", OW'(in_ready), OW'(1));
    chk("rst_out_data", out_data, '0);
`ifdef ENCRYPTER_MODE_CNT_EN
    chk("rst_mode_cnt", OW'(mode_cnt), '0);
`endif
    @(negedge Clk);
    Rst = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].ld) load_seed(vecs[i].sd);
      send_check($sformatf("vec%0d", i), 1'b0, 16'h0000, vecs[i].d,
                 {vecs[i].m, vecs[i].l, vecs[i].c});
    end

    // Zero seed together with an accept: word keeps old L, next uses ACE1.
    load_seed(16'h0004);
    send_check("seed0_same", 1'b1, 16'h0000, '0, {2'd0, 16'h0004, 60'h004000400040004});
    send_check("seed0_next", 1'b0, 16'h0000, '0, {2'd1, 16'hACE1, 60'hCE1ACE1ACE1ACE1});

    // Streaming with a 5-cycle output stall.
    load_seed(16'h1234);
    ml = 16'h1234;
    sent = 0;
    got = 0;
    stalled_prev = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      @(negedge Clk);
      out_ready = (cyc >= 5);
      in_valid  = (sent < 8);
      in_data   = stream_word(sent);
      #1;
      if (stalled_prev) chk("stall_hold", out_data, held);
      if (sent == 2 && !out_ready) chk("full_in_ready", OW'(in_ready), OW'(0));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("stream_extra", out_data, '0);
        end else begin
          exp_w = exp_q.pop_front();
          chk($sformatf("stream%0d", got), out_data, exp_w);
        end
        got++;
      end
      stalled_prev = out_valid && !out_ready;
      held = out_data;
      if (in_valid && in_ready) begin
        exp_q.push_back(enc(in_data, ml));
        ml = lfsr_next(ml);
        sent++;
      end
    end
    chk("stream_count", OW'(got), OW'(8));
    in_valid = 1'b0;

    // Reset with two words in flight.
    @(negedge Clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 60'h111111111111111;
    @(negedge Clk);
    in_data   = 60'h222222222222222;
    @(negedge Clk);
    in_valid  = 1'b0;
    #1;
    chk("inflight_valid", OW'(out_valid), OW'(1));
    chk("inflight_in_ready", OW'(in_ready), OW'(0));
    #1 Rst = 1'b1;
    #1;
    chk("midrst_out_valid", OW'(out_valid), OW'(0));
    chk("midrst_in_ready", OW'(in_ready), OW'(1));
    chk("midrst_out_data", out_data, '0);
    @(negedge Clk);
    Rst = 1'b0;
    send_check("post_rst", 1'b0, 16'h0000, '0, {2'd1, 16'hACE1, 60'hCE1ACE1ACE1ACE1});

`ifdef ENCRYPTER_MODE_CNT_EN
    // 1000 random words with random backpressure; counters against model tally.
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk("cnt_clear", OW'(mode_cnt), '0);
    ml = 16'hACE1;
    sent = 0;
    got = 0;
    exp_q.delete();
    for (int m = 0; m < 4; m++) tally[m] = 0;
    for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
      @(negedge Clk);
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = DW'({$urandom, $urandom});
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand_extra", out_data, '0);
        end else begin
          exp_w = exp_q.pop_front();
          chk("rand_word", out_data, exp_w);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(enc(in_data, ml));
        tally[ml[1:0]]++;
        ml = lfsr_next(ml);
        sent++;
      end
    end
    in_valid = 1'b0;
    @(negedge Clk);
    #1;
    chk("rand_count", OW'(got), OW'(1000));
    for (int m = 0; m < 4; m++)
      chk($sformatf("mode_cnt%0d", m), OW'(mode_cnt[m*16 +: 16]), OW'(tally[m]));
    chk("mode_cnt_sum", OW'(32'(mode_cnt[15:0]) + 32'(mode_cnt[31:16]) +
                            32'(mode_cnt[47:32]) + 32'(mode_cnt[63:48])), OW'(1000));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
